// File: rtl/uart_frame_pkg.sv
// Shared definitions for the player-position UART link. Both the transmit
// framer and the receive-side decoder import this package.
//
// Frame layout (byte 0..6):
//   0: FRAME_HDR
//   1: {4'h0, x[11:8]}   2: x[7:0]
//   3: {4'h0, y[11:8]}   4: y[7:0]
//   5: {6'h0, level}     6: XOR of bytes 1..5
package uart_frame_pkg;

   localparam logic [7:0] FRAME_HDR = 8'hA5;
   localparam int         FRAME_LEN = 7;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [1:0]  level;
   } player_pos_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } tx_state_t;

   // Checksum over the payload bytes 1..5; the zero-padded upper nibbles and
   // bits keep it identical on both ends of the link.
   function automatic logic [7:0] frame_chk(input player_pos_t p);
      return {4'h0, p.x[11:8]} ^ p.x[7:0] ^
             {4'h0, p.y[11:8]} ^ p.y[7:0] ^
             {6'h0, p.level};
   endfunction

endpackage

// File: rtl/player_pos_uart_tx.sv
// Transmit side of the player-position link. On frame_tick the local player's
// x/y/level are snapshotted and, if a send is permitted, streamed as a 7-byte
// frame over a valid/ready byte interface to the UART transmitter core.
//
// Ports:
//   clk         system (pixel) clock
//   rst         synchronous, active-high reset
//   frame_tick  one-cycle start-of-vblank strobe requesting a send
//   x_value     local player x (12 bits)
//   y_value     local player y (12 bits)
//   level       local player level index (2 bits)
//   tx_data     byte to uart_tx (registered)
//   tx_valid    tx_data valid, held until accepted (registered)
//   tx_ready    uart_tx accepts a byte when tx_valid & tx_ready
//   busy        frame in progress (state != IDLE)
//   frame_done  one-cycle pulse after the last byte is accepted
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for frame_tick; snapshot and decide whether to send
// SEND  | presenting frame bytes 0..6 one at a time
// DONE  | frame_done pulse; record last-sent snapshot, clear tick count
module player_pos_uart_tx
   import uart_frame_pkg::*;
#(
   parameter int SEND_ON_CHANGE = 1,
   parameter int FORCE_PERIOD   = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic [11:0] x_value,
   input  logic [11:0] y_value,
   input  logic [1:0]  level,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

   tx_state_t   state, state_nxt;
   logic [2:0]  byte_idx, byte_idx_nxt;
   logic [7:0]  tick_cnt, tick_cnt_nxt;
   logic [7:0]  tx_data_nxt;
   logic        tx_valid_nxt;
   logic        force_send, force_send_nxt;
   player_pos_t snap, snap_nxt;
   player_pos_t last_sent, last_sent_nxt;
   player_pos_t pos_in;
   logic        send_ok;

   function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                             input player_pos_t p);
      logic [7:0] b;
      case (idx)
         3'd0:    b = FRAME_HDR;
         3'd1:    b = {4'h0, p.x[11:8]};
         3'd2:    b = p.x[7:0];
         3'd3:    b = {4'h0, p.y[11:8]};
         3'd4:    b = p.y[7:0];
         3'd5:    b = {6'h0, p.level};
         3'd6:    b = frame_chk(p);
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign pos_in = {x_value, y_value, level};

   // Compared against the incoming values because the snapshot is latched on
   // the same edge that decides whether to send.
   always_comb begin
      send_ok = 1'b0;
      if (SEND_ON_CHANGE == 0)
         send_ok = 1'b1;
      else if (force_send)
         send_ok = 1'b1;
      else if (pos_in != last_sent)
         send_ok = 1'b1;
      else if (({1'b0, tick_cnt} + 9'd1) >= 9'(FORCE_PERIOD))
         send_ok = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         byte_idx   <= 3'd0;
         tick_cnt   <= 8'd0;
         tx_data    <= 8'h00;
         tx_valid   <= 1'b0;
         force_send <= 1'b1;
         snap       <= '0;
         last_sent  <= '0;
      end else begin
         state      <= state_nxt;
         byte_idx   <= byte_idx_nxt;
         tick_cnt   <= tick_cnt_nxt;
         tx_data    <= tx_data_nxt;
         tx_valid   <= tx_valid_nxt;
         force_send <= force_send_nxt;
         snap       <= snap_nxt;
         last_sent  <= last_sent_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      byte_idx_nxt   = byte_idx;
      tick_cnt_nxt   = tick_cnt;
      tx_data_nxt    = tx_data;
      tx_valid_nxt   = tx_valid;
      force_send_nxt = force_send;
      snap_nxt       = snap;
      last_sent_nxt  = last_sent;

      case (state)
         IDLE: begin
            tx_valid_nxt = 1'b0;
            if (frame_tick) begin
               snap_nxt     = pos_in;
               tick_cnt_nxt = (tick_cnt == 8'hFF) ? tick_cnt : tick_cnt + 8'd1;
               if (send_ok) begin
                  state_nxt    = SEND;
                  byte_idx_nxt = 3'd0;
                  tx_valid_nxt = 1'b1;
                  tx_data_nxt  = FRAME_HDR;
               end
            end
         end

         SEND: begin
            // Outputs only move on a handshake, so they hold under backpressure.
            if (tx_valid && tx_ready) begin
               if (byte_idx == LAST_IDX) begin
                  state_nxt    = DONE;
                  tx_valid_nxt = 1'b0;
               end else begin
                  byte_idx_nxt = byte_idx + 3'd1;
                  tx_data_nxt  = frame_byte(byte_idx + 3'd1, snap);
               end
            end
         end

         DONE: begin
            tx_valid_nxt   = 1'b0;
            last_sent_nxt  = snap;
            tick_cnt_nxt   = 8'd0;
            force_send_nxt = 1'b0;
            byte_idx_nxt   = 3'd0;
            state_nxt      = IDLE;
         end

         default: begin
            state_nxt    = IDLE;
            tx_valid_nxt = 1'b0;
         end
      endcase
   end

   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

endmodule

// File: tb/tb_player_pos_uart_tx.sv
module tb_player_pos_uart_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic [11:0] x_value;
   logic [11:0] y_value;
   logic [1:0]  level;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   player_pos_uart_tx #(.SEND_ON_CHANGE(1), .FORCE_PERIOD(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .x_value    (x_value),
      .y_value    (y_value),
      .level      (level),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic set_pos(input logic [11:0] x, input logic [11:0] y, input logic [1:0] l);
      x_value = x;
      y_value = y;
      level   = l;
   endtask

   // Called one cycle after the tick edge. toggle: tx_ready alternates 1/0.
   // inject: raise frame_tick at tick+3 with new inputs (x=y=FFF, level=3).
   task automatic run_frame(input logic [7:0] exp [0:6], input bit toggle,
                            input bit inject, input string tag);
      int          k    = 0;
      int          cyc  = 0;
      bit          hold = 0;
      logic [7:0]  held = 8'h00;
      while (k < 7 && cyc < 60) begin
         if (hold) begin
            chk($sformatf("%s_stable", tag), {24'h0, tx_data}, {24'h0, held});
            hold = 0;
         end
         if (cyc == 1)
            chk($sformatf("%s_busy", tag), {31'h0, busy}, 32'd1);
         if (inject && cyc == 2) begin
            frame_tick = 1'b1;
            set_pos(12'hFFF, 12'hFFF, 2'd3);
         end else begin
            frame_tick = 1'b0;
         end
         tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (tx_valid && tx_ready) begin
            chk($sformatf("%s_b%0d", tag, k), {24'h0, tx_data}, {24'h0, exp[k]});
            k++;
         end else if (tx_valid) begin
            held = tx_data;
            hold = 1;
         end
         step();
         cyc++;
      end
      frame_tick = 1'b0;
      chk($sformatf("%s_count", tag), k, 7);
      if (!toggle)
         chk($sformatf("%s_lat", tag), cyc, 7);
      chk($sformatf("%s_done", tag), {31'h0, frame_done}, 32'd1);
      chk($sformatf("%s_vld_low", tag), {31'h0, tx_valid}, 32'd0);
      step();
      chk($sformatf("%s_done_pulse", tag), {31'h0, frame_done}, 32'd0);
      chk($sformatf("%s_idle", tag), {31'h0, busy}, 32'd0);
   endtask

   task automatic expect_no_send(input string tag);
      do_tick();
      chk($sformatf("%s_busy", tag), {31'h0, busy}, 32'd0);
      chk($sformatf("%s_vld", tag), {31'h0, tx_valid}, 32'd0);
      step();
   endtask

   logic [7:0] f_a [0:6] = '{8'hA5, 8'h01, 8'h23, 8'h00, 8'hFE, 8'h02, 8'hDE};
   logic [7:0] f_b [0:6] = '{8'hA5, 8'h04, 8'h56, 8'h07, 8'h89, 8'h01, 8'hDD};
   logic [7:0] f_c [0:6] = '{8'hA5, 8'h04, 8'h57, 8'h07, 8'h89, 8'h01, 8'hDC};
   logic [7:0] f_m [0:6] = '{8'hA5, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h03, 8'h03};

   initial begin
      rst        = 1'b1;
      frame_tick = 1'b0;
      tx_ready   = 1'b0;
      set_pos(12'h123, 12'h0FE, 2'd2);
      step();
      step();
      chk("rst_vld",  {31'h0, tx_valid},   32'd0);
      chk("rst_data", {24'h0, tx_data},    32'd0);
      chk("rst_busy", {31'h0, busy},       32'd0);
      chk("rst_done", {31'h0, frame_done}, 32'd0);
      rst = 1'b0;
      step();

      // Basic frame, tx_ready held high.
      do_tick();
      chk("lat_vld", {31'h0, tx_valid}, 32'd1);
      run_frame(f_a, 1'b0, 1'b0, "basic");

      // Backpressure: ready toggling.
      set_pos(12'h456, 12'h789, 2'd1);
      do_tick();
      run_frame(f_b, 1'b1, 1'b0, "toggle");

      // Keep-alive from a fresh reset: forced first send, then period 3.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      do_tick();
      run_frame(f_b, 1'b0, 1'b0, "ka1");
      expect_no_send("ka2");
      expect_no_send("ka3");
      do_tick();
      run_frame(f_b, 1'b0, 1'b0, "ka4");

      // Input change forces a send on the very next tick.
      set_pos(12'h457, 12'h789, 2'd1);
      do_tick();
      run_frame(f_c, 1'b0, 1'b0, "chg");

      // Mid-frame tick with new inputs is dropped; snapshot is unaffected.
      set_pos(12'h123, 12'h0FE, 2'd2);
      do_tick();
      run_frame(f_a, 1'b0, 1'b1, "mid");
      do_tick();
      run_frame(f_m, 1'b0, 1'b0, "max");

      // Reset while byte 3 is presented abandons the frame.
      set_pos(12'h123, 12'h0FE, 2'd2);
      do_tick();
      tx_ready = 1'b1;
      step();
      step();
      step();
      chk("rst3_byte", {24'h0, tx_data}, 32'h00);
      tx_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst3_vld",  {31'h0, tx_valid}, 32'd0);
      chk("rst3_busy", {31'h0, busy},     32'd0);
      step();
      do_tick();
      run_frame(f_a, 1'b0, 1'b0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
